// File: rtl/fb_scanout.sv
// fb_scanout: prefetches 64-bit framebuffer words from DDR and scans them out as 8-bit pixels with video timing
module fb_scanout #(
  parameter int          H_ACTIVE = 720,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 62,
  parameter int          H_TOTAL  = 858,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 9,
  parameter int          V_SYNC   = 6,
  parameter int          V_TOTAL  = 525,
  parameter logic [27:0] FB_BASE  = 28'd0,
  parameter int          DEPTH    = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_pix,
  output logic [27:0] rd_addr,
  output logic        rd_req,
  input  logic        rd_ready,
  input  logic [63:0] rd_data,
  output logic [7:0]  color,
  output logic        de,
  output logic        hblank,
  output logic        vblank,
  output logic        hs,
  output logic        vs,
  output logic        underrun
);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = $clog2(DEPTH);
  localparam logic [HW-1:0] H_A  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_S0 = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_S1 = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_L  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_A  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_S0 = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_S1 = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_L  = VW'(V_TOTAL - 1);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [27:0]   LAST = FB_BASE + 28'(8 * (H_ACTIVE * V_ACTIVE / 8 - 1));

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_GAP} fetch_t;

  fetch_t        fst;
  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic [2:0]    bsel;
  logic          discard;
  logic          active;
  logic          flush;
  logic          empty;
  logic          push;
  logic          pop;

  assign active = (hc < H_A) && (vc < V_A);
  assign flush  = ce_pix && (vc == V_A) && (hc == '0);
  assign empty  = (cnt == '0);
  assign push   = (fst == F_REQ) && rd_ready && !discard && !flush;
  assign pop    = ce_pix && active && (bsel == 3'd7) && !empty && !flush;

  // raster counters advance one pixel per ce_pix
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (ce_pix) begin
      hc <= (hc == H_L) ? '0 : hc + HW'(1);
      if (hc == H_L) vc <= (vc == V_L) ? '0 : vc + VW'(1);
    end

  // registered video outputs reflect the counters before this pixel's increment
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      color    <= '0;
      de       <= 1'b0;
      hblank   <= 1'b0;
      vblank   <= 1'b0;
      hs       <= 1'b0;
      vs       <= 1'b0;
      underrun <= 1'b0;
    end else if (ce_pix) begin
      color    <= (active && !empty) ? mem[rptr][{bsel, 3'b000} +: 8] : 8'h00;
      de       <= active;
      hblank   <= (hc >= H_A);
      vblank   <= (vc >= V_A);
      hs       <= (hc >= H_S0) && (hc < H_S1);
      vs       <= (vc >= V_S0) && (vc < V_S1);
      if (active && empty) underrun <= 1'b1;
    end

  // prefetch storage; contents need no reset since count gates every read
  always_ff @(posedge clk_sys)
    if (push) mem[wptr] <= rd_data;

  // FIFO pointers, occupancy and byte lane; flush wins over push and pop
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      bsel <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      bsel <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (ce_pix && active) bsel <= bsel + 3'd1;
    end

  // single-outstanding fetch engine; an in-flight word at flush is dropped on arrival
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      fst     <= F_IDLE;
      rd_req  <= 1'b0;
      rd_addr <= FB_BASE;
      discard <= 1'b0;
    end else
      case (fst)
        F_IDLE:
          if (flush) rd_addr <= FB_BASE;
          else if (cnt < FULL) begin
            rd_req <= 1'b1;
            fst    <= F_REQ;
          end
        F_REQ:
          if (rd_ready) begin
            rd_req  <= 1'b0;
            fst     <= F_GAP;
            discard <= 1'b0;
            rd_addr <= (discard || flush || rd_addr == LAST) ? FB_BASE : rd_addr + 28'd8;
          end else if (flush) discard <= 1'b1;
        F_GAP: begin
          fst <= F_IDLE;
          if (flush) rd_addr <= FB_BASE;
        end
        default: fst <= F_IDLE;
      endcase
endmodule
